// File: rtl/somador_serial_ctrl_if.sv
// somador_serial_ctrl_if: start/done handshake plus operand/result bus of the bit-serial adder
//   master: drives inicio, A, B, Cin; observes S, Cout, ocupado, pronto
//   slave : the adder controller side
interface somador_serial_ctrl_if #(parameter int N = 8);
  logic         inicio;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic [N-1:0] S;
  logic         Cout;
  logic         ocupado;
  logic         pronto;
  modport master (output inicio, A, B, Cin, input S, Cout, ocupado, pronto);
  modport slave  (input inicio, A, B, Cin, output S, Cout, ocupado, pronto);
endinterface

// File: rtl/somador_serial_ctrl.sv
// somador_serial_ctrl: N-bit adder built from one 1-bit full adder, one bit per clock, LSB first
//   clk, rst : clock and synchronous active-high reset
//   bus      : inicio/A/B/Cin in, S/Cout/ocupado/pronto out (all outputs registered)
module somador_serial_ctrl #(
  parameter int N = 8
) (
  input logic clk,
  input logic rst,
  somador_serial_ctrl_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {OCIOSO, SOMANDO, FIM} state_t;
  state_t         state;
  logic [N-1:0]   reg_a, reg_b, reg_s, s_next;
  logic           carry, s, c;
  logic [CW-1:0]  cont;
  always_comb begin
    s      = reg_a[0] ^ reg_b[0] ^ carry;
    c      = (reg_a[0] & reg_b[0]) | (carry & (reg_a[0] ^ reg_b[0]));
    // new sum bit enters at the MSB; written as shifts so N=1 needs no special slice
    s_next = (reg_s >> 1) | (N'(s) << (N - 1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= OCIOSO;
      reg_a       <= '0;
      reg_b       <= '0;
      reg_s       <= '0;
      carry       <= 1'b0;
      cont        <= '0;
      bus.S       <= '0;
      bus.Cout    <= 1'b0;
      bus.ocupado <= 1'b0;
      bus.pronto  <= 1'b0;
    end else begin
      case (state)
        OCIOSO: if (bus.inicio) begin
          reg_a       <= bus.A;
          reg_b       <= bus.B;
          carry       <= bus.Cin;
          cont        <= '0;
          bus.ocupado <= 1'b1;
          state       <= SOMANDO;
        end
        SOMANDO: begin
          reg_s <= s_next;
          reg_a <= reg_a >> 1;
          reg_b <= reg_b >> 1;
          carry <= c;
          cont  <= cont + CW'(1);
          if (cont == CW'(N - 1)) begin
            bus.S       <= s_next;
            bus.Cout    <= c;
            bus.ocupado <= 1'b0;
            bus.pronto  <= 1'b1;
            state       <= FIM;
          end
        end
        FIM: begin
          bus.pronto <= 1'b0;
          state      <= OCIOSO;
        end
        default: state <= OCIOSO;
      endcase
    end
  end
endmodule
